tmr_fault_manager: RTL and testbench
====================================

Name: tmr_fault_manager

Overview:
- Sequential consumer of the error flags produced by the 3-input majority voter.
- Tracks per-replica error history and decides between two responses:
  - transient fault: resynchronise the offending replica from the voted value;
  - permanent fault: exclude the replica and drive the voter into two-input (degraded) mode.
- Escalates to a sticky fatal state when a fault can no longer be corrected.
- Sits beside each voter instance in the TMR wrapper; its outputs feed back to the voter and the replica-routing mux.

Parameters:
- THRESHOLD, 4: consecutive sampled errors on one replica that mark it permanently faulty (range 2..15).
- CNT_W, 8: width of the saturating per-replica total error counters.
- RESYNC_CYCLES, 2: cycles resync_o is held for a transient fault (range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- valid_i  input  1  voter flags valid this cycle; flags are sampled only when high.
- err_detected_1_i  input  1  voter port-1 error flag.
- err_detected_2_i  input  1  voter port-2 error flag.
- err_detected_3_i  input  1  voter port-3 error flag.
- err_corrected_i  input  1  voter corrected flag.
- clear_i  input  1  synchronous clear of state, faulty marks and counters.
- only_two_o  output  1  drives voter only_two_i.
- exclude_sel_o  output  2  0 = none, 1..3 = index of excluded replica; the wrapper routes the lower surviving index to voter port 1 and the higher to port 2.
- resync_o  output  3  one-hot replica reload request.
- faulty_o  output  3  sticky permanent-fault marks.
- fatal_o  output  1  uncorrectable condition, sticky.
- state_o  output  2  0 NORMAL, 1 RESYNC, 2 DEGRADED, 3 FATAL.
- err_cnt_1_o  output  CNT_W  total errors attributed to replica 1.
- err_cnt_2_o  output  CNT_W  total errors attributed to replica 2.
- err_cnt_3_o  output  CNT_W  total errors attributed to replica 3.

Behaviour:
- Reset: state NORMAL; every output 0; consecutive counters 0.
- All outputs are registered. An event sampled at edge N is visible after edge N (latency 1).
- clear_i has priority over every other event in every state:
  - next state NORMAL;
  - faulty, counters and resync all cleared.
- NORMAL, sampled valid_i:
  - All three err flags set: next state FATAL. Counters increment for all three replicas (saturating).
  - Exactly one flag k set:
    - err_cnt_k increments (saturating at 2^CNT_W-1) and consec_k increments;
    - the other consec counters clear.
    - If consec_k reaches THRESHOLD: faulty_o[k]=1, exclude_sel_o=k, only_two_o=1, next state DEGRADED; no resync is issued.
    - Otherwise: next state RESYNC with resync_o one-hot on k.
  - No flag set: all consec counters clear.
  - valid_i low: nothing changes.
- RESYNC:
  - resync_o is held for exactly RESYNC_CYCLES cycles, then clears and the state returns to NORMAL.
  - Sampled flags are ignored and consec counters are held, so "consecutive" means consecutive samples taken in NORMAL.
- DEGRADED:
  - Voter flags err_detected_1_i/err_detected_2_i refer to the surviving replicas (low and high index).
  - On a sampled valid_i, either flag set: the counter of the mapped replica increments and next state is FATAL.
  - err_detected_3_i is ignored.
- FATAL:
  - fatal_o=1; only_two_o, exclude_sel_o and faulty_o keep their values.
  - Exits only on clear_i or reset.
- Reset asserted mid-RESYNC: resync_o drops asynchronously.
- The saturating counters never wrap.

Optional Feature:
- Macro TMR_FM_IRQ_EN.
- Defined: extra output port irq_o (1 bit) pulses high for one cycle on every transition into DEGRADED or into FATAL. Reset value 0. A clear_i in the same cycle suppresses the pulse.
- Undefined: irq_o does not exist and there is no related logic. All other behaviour is identical.

Test Plan:
- Single err_detected_2_i on one valid sample → state RESYNC next cycle, resync_o=3'b010 for 2 cycles, err_cnt_2_o=1, then NORMAL.
- err_detected_3_i on 4 successive NORMAL samples, with resyncs between them → after the 4th: faulty_o=3'b100, only_two_o=1, exclude_sel_o=3, resync_o stays 0, state DEGRADED.
- From DEGRADED with replica 1 excluded, err_detected_1_i=1 on a valid sample → fatal_o=1, state FATAL, err_cnt_2_o increments. It remains FATAL for 10 idle cycles, then clear_i returns the state to NORMAL with all outputs 0.
- All three flags set on one valid sample → fatal_o=1 next cycle; err_cnt_1_o, err_cnt_2_o and err_cnt_3_o each equal 1.
- CNT_W=2: replica 1 errors, each followed by a clean sample, repeated 5 times → err_cnt_1_o saturates at 3, no DEGRADED. clear_i together with an erroring valid sample → counters 0, state NORMAL.
- rst_n low during the 2nd RESYNC cycle → resync_o=0 immediately, state NORMAL after release.

Source files
------------

// File: rtl/tmr_fault_manager_if.sv
// Voter-to-fault-manager flag bundle.
// Handshake: valid-only, no back-pressure. The manager samples the error and
// corrected flags on every rising clk edge where valid_i is high and ignores
// them otherwise; the voter drives new flags whenever it likes.
interface tmr_fault_manager_if;
    logic valid_i;
    logic err_detected_1_i;
    logic err_detected_2_i;
    logic err_detected_3_i;
    logic err_corrected_i;

    // Voter side drives the flags
    modport master (
        output valid_i,
        output err_detected_1_i,
        output err_detected_2_i,
        output err_detected_3_i,
        output err_corrected_i
    );

    // Fault manager side consumes them
    modport slave (
        input valid_i,
        input err_detected_1_i,
        input err_detected_2_i,
        input err_detected_3_i,
        input err_corrected_i
    );
endinterface

// File: rtl/tmr_fault_manager.sv
// TMR fault manager: classifies voter error flags into transient faults
// (resync the replica), permanent faults (exclude it, degrade the voter to
// two inputs) and uncorrectable faults (sticky fatal).
// Optional macro TMR_FM_IRQ_EN adds irq_o, a one-cycle pulse on entry to
// DEGRADED or FATAL.
module tmr_fault_manager #(
    parameter int THRESHOLD     = 4,
    parameter int CNT_W         = 8,
    parameter int RESYNC_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    tmr_fault_manager_if.slave flags,
    input  logic               clear_i,
    output logic               only_two_o,
    output logic [1:0]         exclude_sel_o,
    output logic [2:0]         resync_o,
    output logic [2:0]         faulty_o,
    output logic               fatal_o,
    output logic [1:0]         state_o,
    output logic [CNT_W-1:0]   err_cnt_1_o,
    output logic [CNT_W-1:0]   err_cnt_2_o,
    output logic [CNT_W-1:0]   err_cnt_3_o
`ifdef TMR_FM_IRQ_EN
    ,
    output logic               irq_o
`endif
);

    localparam int CONS_W = 4;
    localparam int RS_W   = 4;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CONS_W-1:0] CONS_ONE  = CONS_W'(1);
    localparam logic [CONS_W-1:0] CONS_LAST = CONS_W'(THRESHOLD - 1);
    localparam logic [RS_W-1:0]   RS_ONE    = RS_W'(1);
    localparam logic [RS_W-1:0]   RS_LOAD   = RS_W'(RESYNC_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_RESYNC   = 2'd1,
        ST_DEGRADED = 2'd2,
        ST_FATAL    = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0][CONS_W-1:0]   consec_q, consec_d;
    logic [2:0]               faulty_q, faulty_d;
    logic [2:0]               resync_q, resync_d;
    logic [1:0]               exclude_q, exclude_d;
    logic                     only_two_q, only_two_d;
    logic                     fatal_q, fatal_d;
    logic [RS_W-1:0]          rs_cnt_q, rs_cnt_d;

    // err_corrected is implied by a single flag; kept on the bundle for the voter
    logic unused_corrected;
    assign unused_corrected = flags.err_corrected_i;

    logic [2:0] err_vec;
    logic [1:0] n_err;
    logic       single_err;
    logic       multi_err;
    logic       hit_threshold;
    logic [1:0] err_idx;
    logic [2:0] lo_mask, hi_mask;

    assign err_vec    = {flags.err_detected_3_i, flags.err_detected_2_i, flags.err_detected_1_i};
    assign n_err      = {1'b0, err_vec[0]} + {1'b0, err_vec[1]} + {1'b0, err_vec[2]};
    assign single_err = (n_err == 2'd1);
    assign multi_err  = (n_err >= 2'd2);
    // Only meaningful when exactly one flag is set
    assign err_idx    = {err_vec[1] | err_vec[2], err_vec[0] | err_vec[2]};
    assign hit_threshold = (err_vec[0] && consec_q[0] == CONS_LAST) ||
                           (err_vec[1] && consec_q[1] == CONS_LAST) ||
                           (err_vec[2] && consec_q[2] == CONS_LAST);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Map degraded voter ports 1/2 to the surviving low/high replica
    always_comb begin
        lo_mask = 3'b001;
        hi_mask = 3'b010;
        case (exclude_q)
            2'd1:    begin lo_mask = 3'b010; hi_mask = 3'b100; end
            2'd2:    begin lo_mask = 3'b001; hi_mask = 3'b100; end
            default: begin lo_mask = 3'b001; hi_mask = 3'b010; end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_NORMAL;
        else        state_q <= state_d;
    end

    // Next-state decision; clear wins from every state
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_NORMAL;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (flags.valid_i) begin
                        if (multi_err)       state_d = ST_FATAL;
                        else if (single_err) state_d = hit_threshold ? ST_DEGRADED : ST_RESYNC;
                    end
                end
                ST_RESYNC: begin
                    if (rs_cnt_q == '0) state_d = ST_NORMAL;
                end
                ST_DEGRADED: begin
                    if (flags.valid_i && (err_vec[0] || err_vec[1])) state_d = ST_FATAL;
                end
                ST_FATAL: state_d = ST_FATAL;
            endcase
        end
    end

    // Next values of the registered outputs and history counters
    always_comb begin
        cnt_d      = cnt_q;
        consec_d   = consec_q;
        faulty_d   = faulty_q;
        resync_d   = resync_q;
        exclude_d  = exclude_q;
        only_two_d = only_two_q;
        fatal_d    = fatal_q;
        rs_cnt_d   = rs_cnt_q;
        if (clear_i) begin
            cnt_d      = '0;
            consec_d   = '0;
            faulty_d   = '0;
            resync_d   = '0;
            exclude_d  = '0;
            only_two_d = 1'b0;
            fatal_d    = 1'b0;
            rs_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (flags.valid_i) begin
                        if (multi_err) begin
                            for (int k = 0; k < 3; k++)
                                if (err_vec[k]) cnt_d[k] = sat_inc(cnt_q[k]);
                            fatal_d = 1'b1;
                        end else if (single_err) begin
                            for (int k = 0; k < 3; k++) begin
                                if (err_vec[k]) begin
                                    cnt_d[k]    = sat_inc(cnt_q[k]);
                                    consec_d[k] = consec_q[k] + CONS_ONE;
                                end else begin
                                    consec_d[k] = '0;
                                end
                            end
                            if (hit_threshold) begin
                                faulty_d   = faulty_q | err_vec;
                                exclude_d  = err_idx;
                                only_two_d = 1'b1;
                            end else begin
                                resync_d = err_vec;
                                rs_cnt_d = RS_LOAD;
                            end
                        end else begin
                            consec_d = '0;
                        end
                    end
                end
                ST_RESYNC: begin
                    if (rs_cnt_q == '0) resync_d = '0;
                    else                rs_cnt_d = rs_cnt_q - RS_ONE;
                end
                ST_DEGRADED: begin
                    if (flags.valid_i && (err_vec[0] || err_vec[1])) begin
                        for (int k = 0; k < 3; k++)
                            if ((err_vec[0] && lo_mask[k]) || (err_vec[1] && hi_mask[k]))
                                cnt_d[k] = sat_inc(cnt_q[k]);
                        fatal_d = 1'b1;
                    end
                end
                ST_FATAL: fatal_d = 1'b1;
            endcase
        end
    end

    // Output and history registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            consec_q   <= '0;
            faulty_q   <= '0;
            resync_q   <= '0;
            exclude_q  <= '0;
            only_two_q <= 1'b0;
            fatal_q    <= 1'b0;
            rs_cnt_q   <= '0;
        end else begin
            cnt_q      <= cnt_d;
            consec_q   <= consec_d;
            faulty_q   <= faulty_d;
            resync_q   <= resync_d;
            exclude_q  <= exclude_d;
            only_two_q <= only_two_d;
            fatal_q    <= fatal_d;
            rs_cnt_q   <= rs_cnt_d;
        end
    end

`ifdef TMR_FM_IRQ_EN
    logic irq_q;
    // Pulse on entry into DEGRADED or FATAL, suppressed by a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= !clear_i && (state_d != state_q) &&
                             (state_d == ST_DEGRADED || state_d == ST_FATAL);
    end
    assign irq_o = irq_q;
`else
    // No interrupt output in this build
`endif

    assign state_o       = state_q;
    assign only_two_o    = only_two_q;
    assign exclude_sel_o = exclude_q;
    assign resync_o      = resync_q;
    assign faulty_o      = faulty_q;
    assign fatal_o       = fatal_q;
    assign err_cnt_1_o   = cnt_q[0];
    assign err_cnt_2_o   = cnt_q[1];
    assign err_cnt_3_o   = cnt_q[2];

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Directed bench for tmr_fault_manager (CNT_W=2 so saturation is reachable).
module tb_tmr_fault_manager;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             clear_i;
  logic             only_two_o;
  logic [1:0]       exclude_sel_o;
  logic [2:0]       resync_o;
  logic [2:0]       faulty_o;
  logic             fatal_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] err_cnt_1_o;
  logic [CNT_W-1:0] err_cnt_2_o;
  logic [CNT_W-1:0] err_cnt_3_o;
`ifdef TMR_FM_IRQ_EN
  logic             irq_o;
`endif

  int n_checks;
  int n_fail;

  tmr_fault_manager_if fif();

  tmr_fault_manager #(
    .THRESHOLD(4),
    .CNT_W(CNT_W),
    .RESYNC_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flags(fif),
    .clear_i(clear_i),
    .only_two_o(only_two_o),
    .exclude_sel_o(exclude_sel_o),
    .resync_o(resync_o),
    .faulty_o(faulty_o),
    .fatal_o(fatal_o),
    .state_o(state_o),
    .err_cnt_1_o(err_cnt_1_o),
    .err_cnt_2_o(err_cnt_2_o),
    .err_cnt_3_o(err_cnt_3_o)
`ifdef TMR_FM_IRQ_EN
    ,
    .irq_o(irq_o)
`endif
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic e1, input logic e2, input logic e3, input logic clr);
    fif.valid_i          = v;
    fif.err_detected_1_i = e1;
    fif.err_detected_2_i = e2;
    fif.err_detected_3_i = e3;
    fif.err_corrected_i  = (e1 | e2 | e3) & v;
    clear_i              = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sample(input logic e1, input logic e2, input logic e3);
    drive(1'b1, e1, e2, e3, 1'b0);
    tick();
    idle();
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_state"}, 32'(state_o), 0);
    check_eq({tag, "_outs"}, 32'({only_two_o, exclude_sel_o, resync_o, faulty_o, fatal_o}), 0);
    check_eq({tag, "_cnts"}, 32'({err_cnt_1_o, err_cnt_2_o, err_cnt_3_o}), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // transient fault on replica 2
    sample(1'b0, 1'b1, 1'b0);
    check_eq("t1_state", 32'(state_o), 1);
    check_eq("t1_resync_c1", 32'(resync_o), 'b010);
    check_eq("t1_cnt2", 32'(err_cnt_2_o), 1);
    tick();
    check_eq("t1_resync_c2", 32'(resync_o), 'b010);
    tick();
    check_eq("t1_resync_end", 32'(resync_o), 0);
    check_eq("t1_back_normal", 32'(state_o), 0);

    // replica 3 errors on four consecutive NORMAL samples
    for (int i = 0; i < 3; i++) begin
      sample(1'b0, 1'b0, 1'b1);
      check_eq("t2_resync", 32'(resync_o), 'b100);
      tick();
      tick();
    end
    sample(1'b0, 1'b0, 1'b1);
    check_eq("t2_state", 32'(state_o), 2);
    check_eq("t2_faulty", 32'(faulty_o), 'b100);
    check_eq("t2_only_two", 32'(only_two_o), 1);
    check_eq("t2_exclude", 32'(exclude_sel_o), 3);
    check_eq("t2_no_resync", 32'(resync_o), 0);
    check_eq("t2_cnt3_sat", 32'(err_cnt_3_o), 3);
    // port-3 flag is meaningless while degraded
    sample(1'b0, 1'b0, 1'b1);
    check_eq("t2_e3_ignored", 32'(state_o), 2);
    // exclude=3: voter port 2 is replica 2
    sample(1'b0, 1'b1, 1'b0);
    check_eq("t2_fatal", 32'(fatal_o), 1);
    check_eq("t2_fatal_state", 32'(state_o), 3);
    check_eq("t2_cnt2", 32'(err_cnt_2_o), 2);
    check_eq("t2_cnt1", 32'(err_cnt_1_o), 0);
    repeat (10) tick();
    check_eq("t2_fatal_hold", 32'(state_o), 3);
    check_eq("t2_marks_hold", 32'({only_two_o, exclude_sel_o, faulty_o}), 'b1_11_100);
    do_clear();
    check_all_zero("t2_clear");

    // replica 1 goes permanent, then voter port 1 (replica 2) errors
    for (int i = 0; i < 3; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      tick();
      tick();
    end
    sample(1'b1, 1'b0, 1'b0);
    check_eq("t3_state", 32'(state_o), 2);
    check_eq("t3_exclude", 32'(exclude_sel_o), 1);
    check_eq("t3_faulty", 32'(faulty_o), 'b001);
    sample(1'b1, 1'b0, 1'b0);
    check_eq("t3_fatal", 32'(fatal_o), 1);
    check_eq("t3_state_fatal", 32'(state_o), 3);
    check_eq("t3_cnt2", 32'(err_cnt_2_o), 1);
    check_eq("t3_cnt3", 32'(err_cnt_3_o), 0);
    check_eq("t3_cnt1", 32'(err_cnt_1_o), 3);
    repeat (10) tick();
    check_eq("t3_fatal_hold", 32'(state_o), 3);
    do_clear();
    check_all_zero("t3_clear");

    // all three flags at once
    sample(1'b1, 1'b1, 1'b1);
    check_eq("t4_fatal", 32'(fatal_o), 1);
    check_eq("t4_state", 32'(state_o), 3);
    check_eq("t4_cnts", 32'({err_cnt_1_o, err_cnt_2_o, err_cnt_3_o}), 'b01_01_01);
    check_eq("t4_no_degrade", 32'(only_two_o), 0);
    do_clear();
    check_all_zero("t4_clear");

    // counter saturation without reaching the threshold
    for (int i = 0; i < 5; i++) begin
      sample(1'b1, 1'b0, 1'b0);
      tick();
      tick();
      sample(1'b0, 1'b0, 1'b0);
      if (i == 2) check_eq("t5_cnt1_at3", 32'(err_cnt_1_o), 3);
    end
    check_eq("t5_cnt1_sat", 32'(err_cnt_1_o), 3);
    check_eq("t5_state", 32'(state_o), 0);
    check_eq("t5_no_degrade", 32'({only_two_o, faulty_o}), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    check_all_zero("t5_clear_wins");

    // asynchronous reset during the second RESYNC cycle
    sample(1'b0, 1'b1, 1'b0);
    tick();
    check_eq("t6_resync_c2", 32'(resync_o), 'b010);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_resync_async", 32'(resync_o), 0);
    check_eq("t6_state_async", 32'(state_o), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("t6_after_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
